// File: rtl/bash_hash_params_pkg.sv
// Shared constants, level/state encodings and level-derived sizes for the
// Bash-Hash sponge controller.
package bash_hash_params_pkg;

   localparam int          BASH_F_ROUNDS = 24;
   localparam int          STATE_WORDS   = 24;
   localparam logic [7:0]  PAD_BYTE      = 8'h40;
   localparam logic [63:0] BASH_F_INIT   = 64'hB194_BAC8_0A08_F53B;
   localparam logic [63:0] BASH_F_CONST  = 64'hAED8_E07F_99E1_2BDC;

   typedef enum logic [1:0] {
      LVL_128 = 2'd0,
      LVL_192 = 2'd1,
      LVL_256 = 2'd2
   } level_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_ABSORB,
      ST_PAD,
      ST_PERM,
      ST_SQUEEZE
   } state_t;

   function automatic logic [4:0] rate_words(level_t lvl);
      case (lvl)
         LVL_128: return 5'd16;
         LVL_192: return 5'd12;
         default: return 5'd8;
      endcase
   endfunction

   function automatic logic [4:0] digest_words(level_t lvl);
      case (lvl)
         LVL_128: return 5'd4;
         LVL_192: return 5'd6;
         default: return 5'd8;
      endcase
   endfunction

   // l/4, written into S[23] when a new hash is prepared
   function automatic logic [63:0] init_word(level_t lvl);
      case (lvl)
         LVL_128: return 64'd32;
         LVL_192: return 64'd48;
         default: return 64'd64;
      endcase
   endfunction

endpackage

// File: rtl/bash_f_rc_gen.sv
// bash-f round constant generator: Galois-style shift register that starts
// from BASH_F_INIT and advances one constant per round.
module bash_f_rc_gen
   import bash_hash_params_pkg::*;
(
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        load,
   input  logic        step,
   output logic [63:0] rc
);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rc <= BASH_F_INIT;
      end else if (load) begin
         rc <= BASH_F_INIT;
      end else if (step) begin
         rc <= {1'b0, rc[63:1]} ^ (rc[0] ? BASH_F_CONST : 64'd0);
      end
   end

endmodule

// File: rtl/bash_hash_ctrl.sv
// Bash-Hash sponge sequencer: absorb with padding, 24-round permutation
// sequencing and digest squeeze, driving strobes/indices of the bash-f datapath.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | ready for prep/start
// ST_INIT    | one cycle: clear state, load l/4 into S[23]
// ST_ABSORB  | accept message words into S[wc]
// ST_PAD     | one cycle: pad byte 0 of S[wc] (message ended on a full word)
// ST_PERM    | ROUNDS cycles of bash-f rounds
// ST_SQUEEZE | present digest words S[sc] until consumed
module bash_hash_ctrl
   import bash_hash_params_pkg::*;
#(
   parameter int SLEN   = 64,
   parameter int ROUNDS = BASH_F_ROUNDS
) (
   input  logic            aclk,
   input  logic            aresetn,
   input  logic [1:0]      level_i,
   input  logic            prep_i,
   input  logic            start_i,
   output logic            rdy_o,
   output logic            err_o,
   input  logic            in_valid_i,
   input  logic            in_last_i,
   input  logic [3:0]      in_nbytes_i,
   output logic            in_ready_o,
   output logic            dp_init_o,
   output logic [SLEN-1:0] dp_init_word_o,
   output logic            dp_absorb_o,
   output logic [3:0]      dp_nbytes_o,
   output logic            dp_pad_o,
   output logic [2:0]      dp_pad_byte_o,
   output logic [4:0]      dp_widx_o,
   output logic            dp_round_o,
   output logic [SLEN-1:0] dp_rc_o,
   output logic            out_valid_o,
   output logic            out_last_o,
   input  logic            out_ready_i
);

   state_t      state;
   level_t      level_q;
   logic        primed;
   logic        final_q;
   logic        padpend;
   logic [4:0]  wc;
   logic [4:0]  sc;
   logic [4:0]  rc_cnt;
   logic [4:0]  rate;
   logic [4:0]  digest;
   logic [3:0]  nb_eff;
   logic        short_last;
   logic [63:0] rc_word;

   assign rate   = rate_words(level_q);
   assign digest = digest_words(level_q);

   // Out-of-range byte counts on the last word are treated as a full word.
   assign nb_eff     = !in_last_i ? 4'd8 : ((in_nbytes_i > 4'd8) ? 4'd8 : in_nbytes_i);
   assign short_last = in_last_i && !nb_eff[3];

   bash_f_rc_gen u_rc_gen (
      .aclk    (aclk),
      .aresetn (aresetn),
      .load    (state != ST_PERM),
      .step    (state == ST_PERM),
      .rc      (rc_word)
   );

   assign dp_rc_o = rc_word[SLEN-1:0];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= ST_IDLE;
         level_q <= LVL_128;
         primed  <= 1'b0;
         final_q <= 1'b0;
         padpend <= 1'b0;
         wc      <= '0;
         sc      <= '0;
         rc_cnt  <= '0;
         err_o   <= 1'b0;
      end else begin
         err_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (prep_i) begin
                  if (level_i == 2'd3) begin
                     err_o <= 1'b1;
                  end else begin
                     level_q <= level_t'(level_i);
                     state   <= ST_INIT;
                  end
               end else if (start_i) begin
                  if (primed) begin
                     state   <= ST_ABSORB;
                     wc      <= '0;
                     final_q <= 1'b0;
                     padpend <= 1'b0;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end
            ST_INIT: begin
               primed <= 1'b1;
               state  <= ST_IDLE;
            end
            ST_ABSORB: begin
               if (in_valid_i) begin
                  if (short_last) begin
                     state   <= ST_PERM;
                     final_q <= 1'b1;
                  end else if (wc == rate - 5'd1) begin
                     // block full; a full last word still owes a pad in the next block
                     state   <= ST_PERM;
                     wc      <= '0;
                     final_q <= 1'b0;
                     padpend <= in_last_i;
                  end else begin
                     wc <= wc + 5'd1;
                     if (in_last_i) state <= ST_PAD;
                  end
               end
            end
            ST_PAD: begin
               state   <= ST_PERM;
               final_q <= 1'b1;
               padpend <= 1'b0;
            end
            ST_PERM: begin
               if (rc_cnt == 5'(ROUNDS - 1)) begin
                  rc_cnt <= '0;
                  if (final_q) begin
                     state <= ST_SQUEEZE;
                     sc    <= '0;
                  end else if (padpend) begin
                     state <= ST_PAD;
                  end else begin
                     state <= ST_ABSORB;
                  end
               end else begin
                  rc_cnt <= rc_cnt + 5'd1;
               end
            end
            ST_SQUEEZE: begin
               if (out_ready_i) begin
                  if (sc == digest - 5'd1) begin
                     state  <= ST_IDLE;
                     primed <= 1'b0;
                  end else begin
                     sc <= sc + 5'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rdy_o          = 1'b0;
      in_ready_o     = 1'b0;
      dp_init_o      = 1'b0;
      dp_init_word_o = '0;
      dp_absorb_o    = 1'b0;
      dp_nbytes_o    = 4'd0;
      dp_pad_o       = 1'b0;
      dp_pad_byte_o  = 3'd0;
      dp_widx_o      = 5'd0;
      dp_round_o     = 1'b0;
      out_valid_o    = 1'b0;
      out_last_o     = 1'b0;
      case (state)
         ST_IDLE: rdy_o = 1'b1;
         ST_INIT: begin
            dp_init_o      = 1'b1;
            dp_init_word_o = SLEN'(init_word(level_q));
         end
         ST_ABSORB: begin
            in_ready_o = 1'b1;
            dp_widx_o  = wc;
            if (in_valid_i) begin
               dp_absorb_o   = 1'b1;
               dp_nbytes_o   = nb_eff;
               dp_pad_o      = short_last;
               dp_pad_byte_o = short_last ? nb_eff[2:0] : 3'd0;
            end
         end
         ST_PAD: begin
            dp_pad_o  = 1'b1;
            dp_widx_o = wc;
         end
         ST_PERM: dp_round_o = 1'b1;
         ST_SQUEEZE: begin
            out_valid_o = 1'b1;
            dp_widx_o   = sc;
            out_last_o  = (sc == digest - 5'd1);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bash_hash_ctrl.sv
// Scoreboard bench for bash_hash_ctrl: a message-level sponge model queues the
// expected datapath events, a negedge monitor pops and compares them.
module tb_bash_hash_ctrl;

   localparam logic [63:0] C_FIRST = 64'hB194BAC80A08F53B;
   localparam logic [63:0] C_POLY  = 64'hAED8E07F99E12BDC;
   localparam int          NRND    = 24;

   localparam logic [2:0] EV_INIT  = 3'd0;
   localparam logic [2:0] EV_ABS   = 3'd1;
   localparam logic [2:0] EV_PAD   = 3'd2;
   localparam logic [2:0] EV_ROUND = 3'd3;
   localparam logic [2:0] EV_OUT   = 3'd4;
   localparam logic [2:0] EV_ERR   = 3'd5;

   typedef struct packed {
      logic [2:0]  kind;
      logic [63:0] data;
      logic [4:0]  widx;
      logic [3:0]  nb;
      logic        pad;
      logic [2:0]  pb;
      logic        last;
   } ev_t;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [1:0]  level_i = 2'd0;
   logic        prep_i = 1'b0;
   logic        start_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_last_i = 1'b0;
   logic [3:0]  in_nbytes_i = 4'd0;
   logic        out_ready_i = 1'b0;
   logic        rdy_o, err_o, in_ready_o, dp_init_o, dp_absorb_o, dp_pad_o;
   logic        dp_round_o, out_valid_o, out_last_o;
   logic [63:0] dp_init_word_o, dp_rc_o;
   logic [3:0]  dp_nbytes_o;
   logic [2:0]  dp_pad_byte_o;
   logic [4:0]  dp_widx_o;

   ev_t         sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] rc_tab[NRND];
   logic        hold_pend = 1'b0;
   logic [4:0]  hold_widx = 5'd0;

   bash_hash_ctrl dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .level_i        (level_i),
      .prep_i         (prep_i),
      .start_i        (start_i),
      .rdy_o          (rdy_o),
      .err_o          (err_o),
      .in_valid_i     (in_valid_i),
      .in_last_i      (in_last_i),
      .in_nbytes_i    (in_nbytes_i),
      .in_ready_o     (in_ready_o),
      .dp_init_o      (dp_init_o),
      .dp_init_word_o (dp_init_word_o),
      .dp_absorb_o    (dp_absorb_o),
      .dp_nbytes_o    (dp_nbytes_o),
      .dp_pad_o       (dp_pad_o),
      .dp_pad_byte_o  (dp_pad_byte_o),
      .dp_widx_o      (dp_widx_o),
      .dp_round_o     (dp_round_o),
      .dp_rc_o        (dp_rc_o),
      .out_valid_o    (out_valid_o),
      .out_last_o     (out_last_o),
      .out_ready_i    (out_ready_i)
   );

   always #5 aclk = ~aclk;

   initial begin
      #800000;
      $display("FAIL watchdog actual=still_running required=finished");
      $fatal(1, "watchdog expired");
   end

   // Level-derived sizes straight from l: R = (1536 - 4l)/64... expressed per level step
   function automatic int rate_of(int lvl);
      return 16 - 4 * lvl;
   endfunction

   function automatic int digest_of(int lvl);
      return 4 + 2 * lvl;
   endfunction

   function automatic ev_t mk(logic [2:0] k, logic [63:0] d, int w, int nb, bit p, int pb, bit l);
      ev_t e;
      e.kind = k;
      e.data = d;
      e.widx = 5'(w);
      e.nb   = 4'(nb);
      e.pad  = p;
      e.pb   = 3'(pb);
      e.last = l;
      return e;
   endfunction

   function automatic string ev_str(ev_t e);
      return $sformatf("kind%0d data=%h widx=%0d nb=%0d pad=%0d pb=%0d last=%0d",
                       e.kind, e.data, e.widx, e.nb, e.pad, e.pb, e.last);
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic fail_now(string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   task automatic sb_check(ev_t obs);
      ev_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_errors++;
         $display("FAIL unexpected_event actual=%s required=none", ev_str(obs));
      end else begin
         e = sb.pop_front();
         if (e !== obs) begin
            n_errors++;
            $display("FAIL event actual=%s required=%s", ev_str(obs), ev_str(e));
         end
      end
   endtask

   // Sponge model: the message plus (when it ends on a full word) one pad word
   // is laid out over blocks of R words; a permutation follows each full block
   // and the final one; then the digest words stream out.
   task automatic push_hash(int lvl, int m, int nb);
      int r;
      int t;
      int d;
      bit lst;
      bit p;
      r = rate_of(lvl);
      d = digest_of(lvl);
      t = (nb < 8) ? m : m + 1;
      for (int j = 0; j < t; j++) begin
         if (j < m) begin
            lst = (j == m - 1);
            p   = lst && (nb < 8);
            sb.push_back(mk(EV_ABS, 64'd0, j % r, lst ? nb : 8, p, p ? nb : 0, 1'b0));
         end else begin
            sb.push_back(mk(EV_PAD, 64'd0, j % r, 0, 1'b1, 0, 1'b0));
         end
         if ((j % r == r - 1) || (j == t - 1))
            for (int k = 0; k < NRND; k++)
               sb.push_back(mk(EV_ROUND, rc_tab[k], 0, 0, 1'b0, 0, 1'b0));
      end
      for (int i = 0; i < d; i++)
         sb.push_back(mk(EV_OUT, 64'd0, i, 0, 1'b0, 0, i == d - 1));
   endtask

   always @(negedge aclk) begin
      if (aresetn) begin
         if (dp_init_o)
            sb_check(mk(EV_INIT, dp_init_word_o, 0, 0, 1'b0, 0, 1'b0));
         if (dp_absorb_o)
            sb_check(mk(EV_ABS, 64'd0, int'(dp_widx_o), int'(dp_nbytes_o), dp_pad_o,
                        int'(dp_pad_byte_o), 1'b0));
         else if (dp_pad_o)
            sb_check(mk(EV_PAD, 64'd0, int'(dp_widx_o), 0, 1'b1, int'(dp_pad_byte_o), 1'b0));
         if (dp_round_o) begin
            sb_check(mk(EV_ROUND, dp_rc_o, 0, 0, 1'b0, 0, 1'b0));
            chk("in_ready_during_perm", 64'(in_ready_o), 64'd0);
         end
         if (out_valid_o && out_ready_i)
            sb_check(mk(EV_OUT, 64'd0, int'(dp_widx_o), 0, 1'b0, 0, out_last_o));
         if (err_o)
            sb_check(mk(EV_ERR, 64'd0, 0, 0, 1'b0, 0, 1'b0));
         if (hold_pend) begin
            chk("squeeze_hold_valid", 64'(out_valid_o), 64'd1);
            chk("squeeze_hold_widx", 64'(dp_widx_o), 64'(hold_widx));
         end
         hold_pend = out_valid_o && !out_ready_i;
         hold_widx = dp_widx_o;
      end else begin
         hold_pend = 1'b0;
      end
   end

   always @(posedge aclk) begin
      #1;
      out_ready_i = ($urandom_range(0, 2) != 0);
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic pulse_prep(int lvl);
      level_i = 2'(lvl);
      prep_i  = 1'b1;
      tick();
      prep_i  = 1'b0;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_rdy(string name);
      int n;
      n = 0;
      while (!rdy_o && n < 3000) begin
         tick();
         n++;
      end
      if (!rdy_o) fail_now(name);
   endtask

   task automatic wait_done(string name);
      int n;
      n = 0;
      while (!(rdy_o && sb.size() == 0) && n < 3000) begin
         tick();
         n++;
      end
      if (!(rdy_o && sb.size() == 0)) fail_now(name);
   endtask

   task automatic drain(string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      if (sb.size() != 0) fail_now(name);
      repeat (3) tick();
   endtask

   task automatic send_word(bit last, int nb);
      int n;
      n = 0;
      repeat ($urandom_range(0, 2)) tick();
      in_valid_i  = 1'b1;
      in_last_i   = last;
      in_nbytes_i = last ? 4'(nb) : 4'($urandom_range(0, 15));
      while (!in_ready_o && n < 200) begin
         tick();
         n++;
      end
      if (!in_ready_o) fail_now("in_ready_timeout");
      tick();
      in_valid_i  = 1'b0;
      in_last_i   = 1'b0;
      in_nbytes_i = 4'd0;
   endtask

   task automatic absorb_and_finish(int m, int nb);
      for (int k = 0; k < m; k++) send_word(k == m - 1, nb);
      // requests arriving mid-permutation must be ignored silently
      level_i = 2'd3;
      prep_i  = 1'b1;
      start_i = 1'b1;
      tick();
      prep_i  = 1'b0;
      start_i = 1'b0;
      wait_done("hash_done_timeout");
   endtask

   task automatic run_hash(int lvl, int m, int nb);
      sb.push_back(mk(EV_INIT, 64'(32 + 16 * lvl), 0, 0, 1'b0, 0, 1'b0));
      pulse_prep(lvl);
      wait_rdy("prep_rdy_timeout");
      push_hash(lvl, m, nb);
      pulse_start();
      absorb_and_finish(m, nb);
   endtask

   task automatic check_reset_outputs(string tag);
      chk({tag, "_rdy"}, 64'(rdy_o), 64'd1);
      chk({tag, "_err"}, 64'(err_o), 64'd0);
      chk({tag, "_in_ready"}, 64'(in_ready_o), 64'd0);
      chk({tag, "_init"}, {63'd0, dp_init_o} | dp_init_word_o, 64'd0);
      chk({tag, "_absorb_pad"}, 64'({dp_absorb_o, dp_nbytes_o, dp_pad_o, dp_pad_byte_o}), 64'd0);
      chk({tag, "_widx"}, 64'(dp_widx_o), 64'd0);
      chk({tag, "_round"}, 64'(dp_round_o), 64'd0);
      chk({tag, "_rc"}, dp_rc_o, C_FIRST);
      chk({tag, "_out"}, 64'({out_valid_o, out_last_o}), 64'd0);
   endtask

   initial begin
      logic [63:0] c;
      int lvl;
      int m;
      int nb;
      c = C_FIRST;
      for (int i = 0; i < NRND; i++) begin
         rc_tab[i] = c;
         c = (c >> 1) ^ (c[0] ? C_POLY : 64'd0);
      end

      #12;
      check_reset_outputs("por");
      @(negedge aclk);
      aresetn = 1'b1;
      tick();

      // start with nothing prepared
      sb.push_back(mk(EV_ERR, 64'd0, 0, 0, 1'b0, 0, 1'b0));
      pulse_start();
      drain("err_unprimed_start");

      // invalid level: error, no init
      sb.push_back(mk(EV_ERR, 64'd0, 0, 0, 1'b0, 0, 1'b0));
      pulse_prep(3);
      drain("err_bad_level");
      chk("bad_level_stays_idle", 64'(rdy_o), 64'd1);

      // empty message, l128
      run_hash(0, 1, 0);
      // digest finished: the hash is no longer primed
      sb.push_back(mk(EV_ERR, 64'd0, 0, 0, 1'b0, 0, 1'b0));
      pulse_start();
      drain("err_after_squeeze");

      // exactly one full block with a full last word: pad in a second block
      run_hash(0, 16, 8);
      // l256, full last word mid-block: pad word follows at index 5
      run_hash(2, 5, 8);

      // prep and start together: only the init happens
      sb.push_back(mk(EV_INIT, 64'd48, 0, 0, 1'b0, 0, 1'b0));
      level_i = 2'd1;
      prep_i  = 1'b1;
      start_i = 1'b1;
      tick();
      prep_i  = 1'b0;
      start_i = 1'b0;
      chk("prep_start_in_init", 64'(dp_init_o), 64'd1);
      chk("prep_start_no_absorb", 64'(in_ready_o), 64'd0);
      tick();
      chk("prep_start_back_idle", 64'({rdy_o, in_ready_o}), 64'b10);
      push_hash(1, 13, 8);
      pulse_start();
      absorb_and_finish(13, 8);

      for (int t = 0; t < 10; t++) begin
         lvl = $urandom_range(0, 2);
         m   = $urandom_range(1, 2 * rate_of(lvl) + 3);
         nb  = $urandom_range(0, 8);
         run_hash(lvl, m, nb);
      end

      // abort in the middle of a permutation
      sb.push_back(mk(EV_INIT, 64'd48, 0, 0, 1'b0, 0, 1'b0));
      pulse_prep(1);
      wait_rdy("abort_prep_timeout");
      push_hash(1, 3, 5);
      pulse_start();
      for (int k = 0; k < 3; k++) send_word(k == 2, 5);
      repeat (10) tick();
      chk("abort_round10_active", 64'(dp_round_o), 64'd1);
      chk("abort_round10_rc", dp_rc_o, rc_tab[10]);
      aresetn = 1'b0;
      #1;
      check_reset_outputs("abort");
      sb.delete();
      #6;
      aresetn = 1'b1;
      tick();
      sb.push_back(mk(EV_ERR, 64'd0, 0, 0, 1'b0, 0, 1'b0));
      pulse_start();
      drain("err_after_abort");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
